// File: rtl/counter_pkg.sv
// Shared constants for blocks that instantiate the event/cycle counter.
// No logic here; width default only.
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/counter_if.sv
// Groups the counter's enable/count signals for instantiating blocks.
// master drives enable and observes the count; slave is the counter side.
interface counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) ();

    logic             enable;
    logic [WIDTH-1:0] cout;

    modport master (output enable, input  cout);
    modport slave  (input  enable, output cout);

endinterface

// File: rtl/counter.sv
// Free-running up-counter with enable; count lands on cout one edge after enable is sampled high.
// No backpressure: wraps modulo 2^WIDTH; rst clears asynchronously and beats enable.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] cout
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Natural overflow of the adder provides the wrap to zero.
    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign cout = count_q;

endmodule

// File: tb/tb_counter.sv
// Randomized and directed checks of counter against an integer modulo-2^W reference.
module tb_counter;
    import counter_pkg::*;

    localparam int unsigned W   = CNT_WIDTH_DEFAULT;
    localparam int          MOD = 1 << W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cnt;

    counter_if #(.WIDTH(W)) cif ();

    counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (cif.enable),
        .cout   (cif.cout)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Reference: an integer that goes to zero on reset and adds one per enabled edge.
    always @(posedge rst) exp_cnt = 0;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp_cnt = 0;
        end else if (cif.enable === 1'b1) begin
            exp_cnt = (exp_cnt + 1) % MOD;
        end
    end

    task automatic check_val(input string tag, input logic [W-1:0] obs, input int expv);
        logic [W-1:0] e;
        e = expv[W-1:0];
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: cout=%0h expected=%0h at t=%0t", tag, obs, e, $time);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_val(tag, cif.cout, exp_cnt);
    endtask

    task automatic async_pulse(input string tag);
        rst = 1'b1;
        #1;
        check_val(tag, cif.cout, 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = -1;
        rst        = 1'b0;
        cif.enable = 1'b0;

        // Reset at t=5 with enable undefined, release at t=15.
        #5;
        rst        = 1'b1;
        cif.enable = 1'bx;
        #1 check_val("rst_async", cif.cout, 0);
        #9;
        rst        = 1'b0;
        cif.enable = 1'b0;
        #1 check_val("rst_release", cif.cout, 0);
        #9;
        cif.enable = 1'b1;
        #1 check_val("idle_t26", cif.cout, 0);

        // Ten enabled edges t=30..120, then drop enable at t=125.
        for (int i = 0; i < 10; i++) tick("count_up");
        #4;
        cif.enable = 1'b0;
        check_val("count_reaches_10", cif.cout, 10);
        tick("hold_after_en");
        tick("hold_after_en");

        // Wrap-around from zero.
        async_pulse("rst_before_wrap");
        cif.enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick("wrap_seq");
            check_val("wrap_abs", cif.cout, (i + 1) % MOD);
        end

        // Reach 7, then a 2 ns reset pulse between edges.
        async_pulse("rst_before_7");
        for (int i = 0; i < 7; i++) tick("to_seven");
        check_val("at_seven", cif.cout, 7);
        #2;
        async_pulse("rst_mid_count");
        tick("first_after_pulse");
        check_val("one_after_pulse", cif.cout, 1);

        // rst and enable both high across three edges.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("rst_priority");
            check_val("rst_priority_zero", cif.cout, 0);
        end
        rst = 1'b0;

        // Count to 5, hold four edges, then one more enabled edge.
        for (int i = 0; i < 5; i++) tick("to_five");
        cif.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("hold_five");
            check_val("hold_five_abs", cif.cout, 5);
        end
        cif.enable = 1'b1;
        tick("reenable");
        check_val("six_after_reenable", cif.cout, 6);

        // Random enable with mid-cycle glitches and occasional async resets.
        for (int i = 0; i < 300; i++) begin
            cif.enable = 1'($urandom_range(0, 1));
            #2;
            if ($urandom_range(0, 24) == 0) begin
                async_pulse("rand_rst");
            end
            cif.enable = 1'($urandom_range(0, 1));
            tick("rand_cycle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, checks=%0d required completion", checks);
        $fatal(1, "timeout");
    end

endmodule
